// File: rtl/mesh_feeder.sv
// Skewing front end for the 4x4 Mesh: takes one k-slice per beat, delays lane i by i
// cycles, and drives the staggered per-row propagate bit plus optional zero drain tiles.
module mesh_feeder #(
  parameter int unsigned DIM    = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DWIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIM*WIDTH-1:0]   in_a,
  input  logic [DIM*WIDTH-1:0]   in_b,
  input  logic                   in_last,
  input  logic                   in_drain,
  output logic [WIDTH-1:0]       out_a_0,
  output logic [WIDTH-1:0]       out_a_1,
  output logic [WIDTH-1:0]       out_a_2,
  output logic [WIDTH-1:0]       out_a_3,
  output logic [WIDTH-1:0]       out_b_0,
  output logic [WIDTH-1:0]       out_b_1,
  output logic [WIDTH-1:0]       out_b_2,
  output logic [WIDTH-1:0]       out_b_3,
  output logic [DWIDTH-1:0]      out_d_0,
  output logic [DWIDTH-1:0]      out_d_1,
  output logic [DWIDTH-1:0]      out_d_2,
  output logic [DWIDTH-1:0]      out_d_3,
  output logic                   out_prop_0,
  output logic                   out_prop_1,
  output logic                   out_prop_2,
  output logic                   out_prop_3,
  output logic                   busy,
  output logic [7:0]             tile_count,
  output logic                   protocol_err
);

  typedef enum logic {ST_STREAM = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic               tprop_q, tprop_d;
  logic               drain_pend_q, drain_pend_d;
  logic               rdy_en_q, rdy_en_d;
  logic [7:0]         tile_count_q, tile_count_d;
  logic               perr_q, perr_d;

  logic               accept;
  logic               drain_start;
  logic [DIM*WIDTH-1:0] s0_a, s0_b;
  logic [DIM-1:0]     lane_nz;
  logic [WIDTH-1:0]   out_a_w [DIM];
  logic [WIDTH-1:0]   out_b_w [DIM];
  logic [DIM-1:0]     out_p_w;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_STREAM;
      k_q          <= 2'd0;
      tprop_q      <= 1'b0;
      drain_pend_q <= 1'b0;
      rdy_en_q     <= 1'b0;
      tile_count_q <= 8'd0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      tprop_q      <= tprop_d;
      drain_pend_q <= drain_pend_d;
      rdy_en_q     <= rdy_en_d;
      tile_count_q <= tile_count_d;
      perr_q       <= perr_d;
    end
  end

  // Next-state: a drain starting at k==0 already emits its first zero slice on that edge
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    tprop_d      = tprop_q;
    drain_pend_d = drain_pend_q;
    rdy_en_d     = 1'b1;
    tile_count_d = tile_count_q;
    perr_d       = perr_q;
    if (state_q == ST_STREAM) begin
      if (drain_start) begin
        state_d      = ST_DRAIN;
        k_d          = 2'd1;
        drain_pend_d = 1'b0;
      end else begin
        if (in_drain) drain_pend_d = 1'b1;
        if (accept) begin
          k_d = k_q + 2'd1;
          if (in_last != (k_q == 2'd3)) perr_d = 1'b1;
          if (k_q == 2'd3) begin
            tprop_d      = ~tprop_q;
            tile_count_d = tile_count_q + 8'd1;
          end
        end
      end
    end else begin
      if (in_drain) drain_pend_d = 1'b1;
      k_d = k_q + 2'd1;
      if (k_q == 2'd3) begin
        state_d = ST_STREAM;
        tprop_d = ~tprop_q;
      end
    end
  end

  // Outputs: handshake, busy and the stage-0 slice (zero on bubbles and drain)
  always_comb begin
    in_ready    = rdy_en_q && (state_q == ST_STREAM) &&
                  !((k_q == 2'd0) && (drain_pend_q || in_drain));
    drain_start = rdy_en_q && (state_q == ST_STREAM) && (k_q == 2'd0) &&
                  (drain_pend_q || in_drain);
    accept      = in_valid && in_ready;
    s0_a        = accept ? in_a : '0;
    s0_b        = accept ? in_b : '0;
    busy        = (state_q == ST_DRAIN) || (|lane_nz) || (k_q != 2'd0);
  end

  for (genvar l = 0; l < DIM; l++) begin : g_lane
    logic [l:0][WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [l:0]            p_sr_q, p_sr_d;
    logic [WIDTH-1:0]      oa_q, ob_q;
    logic                  op_q;

    if (l == 0) begin : g_first
      always_comb begin
        a_sr_d = s0_a[l*WIDTH +: WIDTH];
        b_sr_d = s0_b[l*WIDTH +: WIDTH];
        p_sr_d = tprop_q;
      end
    end else begin : g_deep
      always_comb begin
        a_sr_d = {a_sr_q[l-1:0], s0_a[l*WIDTH +: WIDTH]};
        b_sr_d = {b_sr_q[l-1:0], s0_b[l*WIDTH +: WIDTH]};
        p_sr_d = {p_sr_q[l-1:0], tprop_q};
      end
    end

    // Lane i: i+1 skew stages followed by the output register
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        a_sr_q <= '0;
        b_sr_q <= '0;
        p_sr_q <= '0;
        oa_q   <= '0;
        ob_q   <= '0;
        op_q   <= 1'b0;
      end else begin
        a_sr_q <= a_sr_d;
        b_sr_q <= b_sr_d;
        p_sr_q <= p_sr_d;
        oa_q   <= a_sr_q[l];
        ob_q   <= b_sr_q[l];
        op_q   <= p_sr_q[l];
      end
    end

    assign lane_nz[l] = (|a_sr_q) || (|b_sr_q);
    assign out_a_w[l] = oa_q;
    assign out_b_w[l] = ob_q;
    assign out_p_w[l] = op_q;
  end

  assign out_a_0      = out_a_w[0];
  assign out_a_1      = out_a_w[1];
  assign out_a_2      = out_a_w[2];
  assign out_a_3      = out_a_w[3];
  assign out_b_0      = out_b_w[0];
  assign out_b_1      = out_b_w[1];
  assign out_b_2      = out_b_w[2];
  assign out_b_3      = out_b_w[3];
  assign out_prop_0   = out_p_w[0];
  assign out_prop_1   = out_p_w[1];
  assign out_prop_2   = out_p_w[2];
  assign out_prop_3   = out_p_w[3];
  assign out_d_0      = '0;
  assign out_d_1      = '0;
  assign out_d_2      = '0;
  assign out_d_3      = '0;
  assign tile_count   = tile_count_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_mesh_feeder.sv
// Scoreboard bench for mesh_feeder: stimulus pushes expected stage-0 slices per lane,
// a negedge monitor pops them once the skew delay has elapsed and compares the outputs.
module tb_mesh_feeder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_last, in_drain;
  logic [31:0] in_a, in_b;
  logic        in_ready, busy, protocol_err;
  logic [7:0]  out_a_0, out_a_1, out_a_2, out_a_3;
  logic [7:0]  out_b_0, out_b_1, out_b_2, out_b_3;
  logic [15:0] out_d_0, out_d_1, out_d_2, out_d_3;
  logic        out_prop_0, out_prop_1, out_prop_2, out_prop_3;
  logic [7:0]  tile_count;

  always #5 clock = ~clock;

  mesh_feeder dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .in_drain(in_drain),
    .out_a_0(out_a_0), .out_a_1(out_a_1), .out_a_2(out_a_2), .out_a_3(out_a_3),
    .out_b_0(out_b_0), .out_b_1(out_b_1), .out_b_2(out_b_2), .out_b_3(out_b_3),
    .out_d_0(out_d_0), .out_d_1(out_d_1), .out_d_2(out_d_2), .out_d_3(out_d_3),
    .out_prop_0(out_prop_0), .out_prop_1(out_prop_1),
    .out_prop_2(out_prop_2), .out_prop_3(out_prop_3),
    .busy(busy), .tile_count(tile_count), .protocol_err(protocol_err)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       p;
  } lane_t;

  lane_t lq [4][$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference state of the feeder's control
  int   m_k, m_state, m_tiles;
  logic m_tprop, m_pend, m_rdy, m_perr;

  logic [7:0] oa [4];
  logic [7:0] ob [4];
  logic [3:0] op;
  assign oa[0] = out_a_0; assign oa[1] = out_a_1; assign oa[2] = out_a_2; assign oa[3] = out_a_3;
  assign ob[0] = out_b_0; assign ob[1] = out_b_1; assign ob[2] = out_b_2; assign ob[3] = out_b_3;
  assign op = {out_prop_3, out_prop_2, out_prop_1, out_prop_0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    lane_t z;
    z.a = 8'd0; z.b = 8'd0; z.p = 1'b0;
    m_k = 0; m_state = 0; m_tiles = 0;
    m_tprop = 1'b0; m_pend = 1'b0; m_rdy = 1'b0; m_perr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lq[i].delete();
      for (int j = 0; j <= i; j++) lq[i].push_back(z);
    end
  endtask

  // One clock: drive inputs, check in_ready, predict stage-0 slice, advance model
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic last, input logic drain, output logic rdy_seen);
    logic exp_rdy, acc, start;
    lane_t e;
    in_valid = v; in_a = a; in_b = b; in_last = last; in_drain = drain;
    exp_rdy = m_rdy && (m_state == 0) && !((m_k == 0) && (m_pend || drain));
    start   = m_rdy && (m_state == 0) && (m_k == 0) && (m_pend || drain);
    acc     = v && exp_rdy;
    #1;
    rdy_seen = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      e.a = acc ? a[8*i +: 8] : 8'd0;
      e.b = acc ? b[8*i +: 8] : 8'd0;
      e.p = m_tprop;
      lq[i].push_back(e);
    end
    if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_k = 1; m_pend = 1'b0;
      end else begin
        if (drain) m_pend = 1'b1;
        if (acc) begin
          if (last != (m_k == 3)) m_perr = 1'b1;
          if (m_k == 3) begin
            m_tprop = ~m_tprop;
            m_tiles = (m_tiles + 1) % 256;
          end
          m_k = (m_k + 1) % 4;
        end
      end
    end else begin
      if (drain) m_pend = 1'b1;
      if (m_k == 3) begin
        m_state = 0;
        m_tprop = ~m_tprop;
      end
      m_k = (m_k + 1) % 4;
    end
    m_rdy = 1'b1;
    #2;
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, r);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_a"}, {out_a_3, out_a_2, out_a_1, out_a_0}, 32'd0);
    chk({nm, "_b"}, {out_b_3, out_b_2, out_b_1, out_b_0}, 32'd0);
    chk({nm, "_prop"}, {28'd0, op}, 32'd0);
    chk({nm, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_tiles"}, {24'd0, tile_count}, 32'd0);
    chk({nm, "_perr"}, {31'd0, protocol_err}, 32'd0);
  endtask

  // Monitor: lane i shows the slice pushed i+1 edges before the current one
  always @(negedge clock) begin
    if (reset_n) begin
      logic exp_busy;
      lane_t e;
      exp_busy = (m_state == 1) || (m_k != 0);
      for (int i = 0; i < 4; i++) begin
        if (lq[i].size() >= i + 2) begin
          e = lq[i].pop_front();
          chk($sformatf("lane%0d_a", i), {24'd0, oa[i]}, {24'd0, e.a});
          chk($sformatf("lane%0d_b", i), {24'd0, ob[i]}, {24'd0, e.b});
          chk($sformatf("lane%0d_prop", i), {31'd0, op[i]}, {31'd0, e.p});
        end
        foreach (lq[i][j]) if (lq[i][j].a != 8'd0 || lq[i][j].b != 8'd0) exp_busy = 1'b1;
      end
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("tile_count", {24'd0, tile_count}, m_tiles);
      chk("protocol_err", {31'd0, protocol_err}, {31'd0, m_perr});
      chk("out_d", {out_d_3, out_d_2} | {out_d_1, out_d_0}, 32'd0);
    end
  end

  initial begin
    logic r;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_drain = 1'b0;
    reset_n = 1'b0;
    reset_model();
    #12;
    check_all_zero("reset");
    @(negedge clock); reset_n = 1'b1;

    // First cycle after reset release is not ready yet
    idle(1);

    // Single beat through all lanes
    cyc(1'b1, 32'h04030201, 32'h08070605, 1'b0, 1'b0, r);
    chk("single_ready", {31'd0, r}, 32'd1);
    idle(1);
    chk("single_a0", {24'd0, out_a_0}, 32'd1);
    chk("single_b0", {24'd0, out_b_0}, 32'd5);
    chk("single_a1_early", {24'd0, out_a_1}, 32'd0);
    idle(3);
    chk("single_a3", {24'd0, out_a_3}, 32'd4);
    chk("single_b3", {24'd0, out_b_3}, 32'd8);
    chk("single_a0_after", {24'd0, out_a_0}, 32'd0);
    idle(2);

    // Reset mid-tile (k==1): everything clears at once
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    reset_model();
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
    idle(1);

    // Two contiguous tiles
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 32'h01010101 * (k + 2), 32'h10203040 + k, 1'b1 ? (k % 4 == 3) : 1'b0, 1'b0, r);
      if (k == 7) chk("tiles_prop_stagger", {28'd0, op}, 32'h7);
    end
    idle(6);
    chk("two_tiles_count", {24'd0, tile_count}, 32'd2);

    // Bubble of two cycles after beat 1
    cyc(1'b1, 32'h00000102, 32'h00000304, 1'b0, 1'b0, r);
    cyc(1'b1, 32'h00000506, 32'h00000708, 1'b0, 1'b0, r);
    idle(2);
    cyc(1'b1, 32'h0000090a, 32'h00000b0c, 1'b0, 1'b0, r);
    cyc(1'b1, 32'h00000d0e, 32'h00000f10, 1'b1, 1'b0, r);
    idle(6);
    chk("bubble_count", {24'd0, tile_count}, 32'd3);
    chk("bubble_perr", {31'd0, protocol_err}, 32'd0);

    // Drain pulse during beat 2: beat 3 still accepted, then 4 drain cycles
    cyc(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0, r);
    cyc(1'b1, 32'h33333333, 32'h44444444, 1'b0, 1'b0, r);
    cyc(1'b1, 32'h55555555, 32'h66666666, 1'b0, 1'b1, r);
    cyc(1'b1, 32'h77777777, 32'h88888888, 1'b1, 1'b0, r);
    chk("drain_beat3_ready", {31'd0, r}, 32'd1);
    for (int j = 0; j < 4; j++) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, r);
      chk("drain_ready_low", {31'd0, r}, 32'd0);
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, r);
    chk("drain_ready_back", {31'd0, r}, 32'd1);
    idle(5);
    chk("drain_count", {24'd0, tile_count}, 32'd4);
    chk("drain_idle_busy", {31'd0, busy}, 32'd0);

    // Drain beats a valid slice at k==0; a second pulse queues a back-to-back drain
    cyc(1'b1, 32'h99999999, 32'h99999999, 1'b0, 1'b1, r);
    chk("drain_wins", {31'd0, r}, 32'd0);
    for (int j = 0; j < 7; j++) begin
      cyc(1'b1, 32'h99999999, 32'h99999999, 1'b0, j == 1, r);
      chk("double_drain_ready", {31'd0, r}, 32'd0);
    end
    idle(6);
    chk("double_drain_count", {24'd0, tile_count}, 32'd4);

    // in_last on beat 1: sticky error, tile still closes after beat 3
    cyc(1'b1, 32'h01020304, 32'h05060708, 1'b0, 1'b0, r);
    cyc(1'b1, 32'h090a0b0c, 32'h0d0e0f10, 1'b1, 1'b0, r);
    chk("perr_set", {31'd0, protocol_err}, 32'd1);
    cyc(1'b1, 32'h11121314, 32'h15161718, 1'b0, 1'b0, r);
    cyc(1'b1, 32'h191a1b1c, 32'h1d1e1f20, 1'b1, 1'b0, r);
    idle(8);
    chk("perr_held", {31'd0, protocol_err}, 32'd1);
    chk("final_count", {24'd0, tile_count}, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
